// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: per-register countdowns until a result is
// forwardable, plus a busy counter for the non-pipelined multiplier.
module hazard_scoreboard #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_use_rs_i,
    input  logic        id_use_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        id_mul_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_busy_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Entry 0 is never loaded, so $0 always reads as not pending.
    logic [CNT_W-1:0] cnt [32];
    logic [CNT_W-1:0] mul_cnt;
    logic [15:0]      stall_cnt;

    logic             raw_rs;
    logic             raw_rt;
    logic             mul_hazard;
    logic             issue;
    logic [CNT_W-1:0] load_val;

    always_comb begin
        raw_rs     = id_use_rs_i && (id_rs_i != 5'd0) && (cnt[id_rs_i] != '0);
        raw_rt     = id_use_rt_i && (id_rt_i != 5'd0) && (cnt[id_rt_i] != '0);
        mul_hazard = id_mul_i && (mul_cnt != '0);
        stall_o    = !flush_i && (raw_rs || raw_rt || mul_hazard);
        issue      = !stall_o && !flush_i;
        load_val   = '0;
        if (id_mul_i) begin
            load_val = MUL_LOAD;
        end else if (id_memread_i) begin
            load_val = ONE;
        end
    end

    // Later assignments in this block override the per-register decrement.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < 32; r++) begin
                cnt[5'(r)] <= '0;
            end
            mul_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (cnt[5'(r)] != '0) begin
                    cnt[5'(r)] <= cnt[5'(r)] - ONE;
                end
            end
            if (issue && id_regwrite_i && (id_rd_i != 5'd0)) begin
                cnt[id_rd_i] <= load_val;
            end
            if (mul_cnt != '0) begin
                mul_cnt <= mul_cnt - ONE;
            end
            if (issue && id_mul_i) begin
                mul_cnt <= MUL_LOAD;
            end
            if (stall_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign mul_busy_o  = (mul_cnt != '0);
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: ready-time reference model checked every cycle,
// directed scenarios with literal expectations, and a saturation instance.
module tb_hazard_scoreboard;

    localparam int unsigned MUL_LAT   = 3;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned S_MUL_LAT = 256;
    localparam int unsigned S_CNT_W   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        use_rs = 1'b0, use_rt = 1'b0, regwrite = 1'b0;
    logic        memread = 1'b0, mul = 1'b0, flush = 1'b0;
    logic        stall, busy;
    logic [15:0] scnt;

    logic        s_rst = 1'b1;
    logic        s_mul = 1'b0;
    logic        s_stall, s_busy;
    logic [15:0] s_scnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(use_rs), .id_use_rt_i(use_rt),
        .id_rd_i(id_rd), .id_regwrite_i(regwrite),
        .id_memread_i(memread), .id_mul_i(mul),
        .flush_i(flush),
        .stall_o(stall), .mul_busy_o(busy), .stall_cnt_o(scnt)
    );

    hazard_scoreboard #(.MUL_LAT(S_MUL_LAT), .CNT_W(S_CNT_W)) sat_dut (
        .clk_i(clk), .rst_i(s_rst),
        .id_rs_i(5'd0), .id_rt_i(5'd0),
        .id_use_rs_i(1'b0), .id_use_rt_i(1'b0),
        .id_rd_i(5'd0), .id_regwrite_i(1'b0),
        .id_memread_i(1'b0), .id_mul_i(s_mul),
        .flush_i(1'b0),
        .stall_o(s_stall), .mul_busy_o(s_busy), .stall_cnt_o(s_scnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute cycle at which each register / the multiplier
    // becomes available, instead of countdowns.
    longint cyc = 0;
    longint ready [32] = '{default: 0};
    longint mul_ready = 0;
    int     m_cnt = 0;

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready[r]);
    endfunction

    function automatic bit m_stall();
        return !flush && ((use_rs && pend(id_rs)) || (use_rt && pend(id_rt)) ||
                          (mul && (cyc < mul_ready)));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ready[i] = 0;
            mul_ready = 0;
            m_cnt     = 0;
        end else begin
            bit     s;
            longint lat;
            s = m_stall();
            if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!s && !flush) begin
                lat = mul ? longint'(MUL_LAT) - 1 : (memread ? 1 : 0);
                if (regwrite && id_rd != 5'd0) ready[id_rd] = cyc + 1 + lat;
                if (mul) mul_ready = cyc + longint'(MUL_LAT);
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_stall", longint'(stall), longint'(m_stall()));
        chk("model_busy", longint'(busy), longint'(cyc < mul_ready));
        chk("model_stall_cnt", longint'(scnt), longint'(m_cnt));
    end

    task automatic set_id(input int rs_v, input int rt_v, input bit urs, input bit urt,
                          input int rd_v, input bit rw, input bit mr, input bit ml,
                          input bit fl);
        id_rs = 5'(rs_v); id_rt = 5'(rt_v); use_rs = urs; use_rt = urt;
        id_rd = 5'(rd_v); regwrite = rw; memread = mr; mul = ml; flush = fl;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic main_seq();
        #2;
        chk("reset_stall", longint'(stall), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_cnt", longint'(scnt), 0);
        tick();
        rst = 1'b0;
        nop(); tick();

        // load-use
        set_id(0, 0, 0, 0, 5, 1, 1, 0, 0); chk("lw5_issue", longint'(stall), 0); tick();
        set_id(5, 0, 1, 0, 6, 1, 0, 0, 0); chk("loaduse_stall", longint'(stall), 1); tick();
        chk("loaduse_release", longint'(stall), 0);
        chk("loaduse_cnt", longint'(scnt), 1); tick();

        // ALU-use
        set_id(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        set_id(0, 3, 0, 1, 0, 0, 0, 0, 0); chk("alu_use", longint'(stall), 0); tick();
        chk("alu_use2", longint'(stall), 0); tick();

        // multiply result use, then structural
        set_id(0, 0, 0, 0, 8, 1, 0, 1, 0); chk("mul8_issue", longint'(stall), 0); tick();
        set_id(8, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mul_use_s1", longint'(stall), 1); chk("mul_busy1", longint'(busy), 1); tick();
        chk("mul_use_s2", longint'(stall), 1); tick();
        chk("mul_use_s3", longint'(stall), 0); tick();
        set_id(0, 0, 0, 0, 10, 1, 0, 1, 0); tick();
        set_id(0, 0, 0, 0, 11, 1, 0, 1, 0);
        chk("mul_struct_s1", longint'(stall), 1); chk("mul_struct_b1", longint'(busy), 1); tick();
        chk("mul_struct_s2", longint'(stall), 1); chk("mul_struct_b2", longint'(busy), 1); tick();
        chk("mul_struct_s3", longint'(stall), 0); chk("mul_struct_b3", longint'(busy), 0);
        chk("stall_cnt5", longint'(scnt), 5); tick();

        // $0 and flush
        set_id(0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        set_id(0, 0, 1, 0, 0, 0, 0, 0, 0); chk("r0_no_stall", longint'(stall), 0); tick();
        set_id(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
        set_id(7, 0, 1, 0, 0, 0, 0, 0, 1); chk("flush_no_stall", longint'(stall), 0); tick();
        set_id(7, 0, 1, 0, 0, 0, 0, 0, 0); chk("after_flush", longint'(stall), 0); tick();

        // WAW
        set_id(0, 0, 0, 0, 9, 1, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 9, 1, 0, 0, 0); chk("waw_add", longint'(stall), 0); tick();
        set_id(9, 0, 1, 0, 0, 0, 0, 0, 0); chk("waw_use", longint'(stall), 0); tick();

        // Rs == Rt
        set_id(0, 0, 0, 0, 12, 1, 1, 0, 0); tick();
        set_id(12, 12, 1, 1, 0, 0, 0, 0, 0); chk("rsrt_stall", longint'(stall), 1); tick();
        chk("rsrt_release", longint'(stall), 0); chk("stall_cnt6", longint'(scnt), 6); tick();

        for (int i = 0; i < 3000; i++) begin
            set_id(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
                   int'($urandom_range(0, 7)), $urandom_range(0, 9) < 8,
                   $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
                   $urandom_range(0, 9) < 1);
            tick();
        end

        // async reset mid-stall
        nop(); tick(); tick(); tick();
        set_id(0, 0, 0, 0, 4, 1, 0, 1, 0); tick();
        set_id(4, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", longint'(stall), 1); chk("pre_rst_busy", longint'(busy), 1);
        rst = 1'b1; #1;
        chk("async_rst_stall", longint'(stall), 0);
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_cnt", longint'(scnt), 0);
        tick();
        rst = 1'b0; tick();
        chk("post_rst_use", longint'(stall), 0); tick();
        nop(); tick();
    endtask

    task automatic sat_seq();
        s_mul = 1'b1;
        #1;
        s_rst = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("sat_mid_cnt", longint'(s_scnt), 996);
        chk("sat_mid_stall", longint'(s_stall), 1);
        chk("sat_mid_busy", longint'(s_busy), 1);
        repeat (69000) @(posedge clk);
        #1;
        chk("sat_final_cnt", longint'(s_scnt), 65535);
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
